// File: rtl/nic_pkg.sv
// Shared constants for the PE network interface.
//   - PE register window addresses (2-bit)
//   - packet field positions (64-bit single-flit packet)
//   - status word bit positions and a helper that assembles the status word
package nic_pkg;

  // PE register window
  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Packet fields
  localparam int VC_BIT      = 63;
  localparam int DIR_MSB     = 62;
  localparam int DIR_LSB     = 61;
  localparam int RSV_MSB     = 60;
  localparam int RSV_LSB     = 56;
  localparam int HOP_MSB     = 55;
  localparam int HOP_LSB     = 48;
  localparam int SRC_MSB     = 47;
  localparam int SRC_LSB     = 32;
  localparam int PAYLOAD_MSB = 31;
  localparam int PAYLOAD_LSB = 0;

  // Status word bits
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 15;

  // {48'b0, count[7:0], 6'b0, empty, full}
  function automatic logic [63:0] status_word(input logic [7:0] cnt,
                                              input logic       empty,
                                              input logic       full);
    logic [63:0] w;
    w = '0;
    w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    w[STAT_EMPTY]                = empty;
    w[STAT_FULL]                 = full;
    return w;
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO used for both NIC channels.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-low reset
//   push, din   - enqueue din when push and not full (push while full is dropped)
//   pop         - dequeue the head when pop and not empty
//   head        - current head entry (first-word fall-through)
//   full, empty - occupancy flags
//   count       - number of stored entries, 0..DEPTH
// A push and a pop in the same cycle both take effect; count stays put.
module nic_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_nic.sv
// Network interface between a processing element and a mesh router PE port.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-low reset
//   addr, d_in, nicEn,
//   nicWrEn, d_out      - PE register window: 00 in-data, 01 in-status,
//                         10 out-data, 11 out-status; d_out is registered
//   polarity            - router phase; a packet is injected only when its VC
//                         bit equals polarity
//   net_so, net_do,
//   net_ro              - PE->router channel
//   net_si, net_di,
//   net_ri              - router->PE channel
// Handshake: on both network channels a transfer happens at a rising edge
// exactly when the sender's send bit and the receiver's ready bit are both 1.
// The sender may raise send only with ready high; a send while ready is low is
// a protocol error and its data is ignored.
module pe_nic
  import nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              polarity,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_ro,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_ri
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] out_head, in_head;
  logic              out_full, out_empty, in_full, in_empty;
  logic [CNT_W-1:0]  out_count, in_count;
  logic              out_push, in_push, in_pop;
  logic              pe_read, pe_write;
  logic [DATA_W-1:0] in_stat, out_stat;

  assign pe_read  = nicEn & ~nicWrEn;
  assign pe_write = nicEn & nicWrEn;

  // PE -> router
  assign out_push = pe_write & (addr == ADDR_OUT_DATA);
  // Gating by reset keeps the channel quiet during the reset cycle even if
  // packets were still buffered before it.
  assign net_so   = reset & ~out_empty & net_ro & (out_head[DATA_W-1] == polarity);
  assign net_do   = out_head;

  nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .din   (d_in),
    .pop   (net_so),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // Router -> PE
  assign net_ri  = ~in_full & reset;
  assign in_push = net_si & net_ri;
  assign in_pop  = pe_read & (addr == ADDR_IN_DATA) & ~in_empty;

  nic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .din   (net_di),
    .pop   (in_pop),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  assign in_stat  = DATA_W'(status_word(8'(in_count), in_empty, in_full));
  assign out_stat = DATA_W'(status_word(8'(out_count), out_empty, out_full));

  // PE read port; holds its value when there is no read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_out <= '0;
    end else if (pe_read) begin
      case (addr)
        ADDR_IN_DATA:  d_out <= in_empty ? '0 : in_head;
        ADDR_IN_STAT:  d_out <= in_stat;
        ADDR_OUT_STAT: d_out <= out_stat;
        default:       d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_nic.sv
module tb_pe_nic;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        polarity;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ro;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ri;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] out_q[$];
  logic [63:0] in_q[$];
  logic [63:0] exp_dout;
  logic [63:0] sent_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pe_nic dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .d_in     (d_in),
    .d_out    (d_out),
    .nicEn    (nicEn),
    .nicWrEn  (nicWrEn),
    .polarity (polarity),
    .net_so   (net_so),
    .net_do   (net_do),
    .net_ro   (net_ro),
    .net_si   (net_si),
    .net_di   (net_di),
    .net_ri   (net_ri)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] stat(input int n);
    logic [63:0] w;
    w = 64'h0;
    w[15:8] = 8'(n);
    w[1]    = (n == 0);
    w[0]    = (n == DEPTH);
    return w;
  endfunction

  // One clock cycle: check combinational outputs against the model, advance
  // the model by the channel rules, cross the edge, then check d_out.
  task automatic step();
    logic exp_so, exp_ri, out_was_full;
    #1;
    exp_so = reset && (out_q.size() > 0) && net_ro && (out_q[0][63] == polarity);
    exp_ri = reset && (in_q.size() < DEPTH);
    check("net_so", 64'(net_so), 64'(exp_so));
    check("net_ri", 64'(net_ri), 64'(exp_ri));
    if (exp_so) check("net_do", net_do, out_q[0]);
    if (net_so) sent_q.push_back(net_do);

    if (!reset) begin
      out_q.delete();
      in_q.delete();
      exp_dout = 64'h0;
    end else begin
      out_was_full = (out_q.size() == DEPTH);
      if (nicEn && !nicWrEn) begin
        case (addr)
          2'b00: exp_dout = (in_q.size() > 0) ? in_q.pop_front() : 64'h0;
          2'b01: exp_dout = stat(in_q.size());
          2'b11: exp_dout = stat(out_q.size());
          default: exp_dout = 64'h0;
        endcase
      end
      if (exp_so) void'(out_q.pop_front());
      if (nicEn && nicWrEn && addr == 2'b10 && !out_was_full) out_q.push_back(d_in);
      if (net_si && exp_ri) in_q.push_back(net_di);
    end

    @(posedge clk);
    #1;
    polarity = ~polarity;
    check("d_out", d_out, exp_dout);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = 64'h0;
  endtask

  task automatic pe_write(input logic [1:0] a, input logic [63:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    step();
    idle();
  endtask

  task automatic pe_read(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    step();
    idle();
  endtask

  task automatic router_send(input logic [63:0] v);
    net_si = 1'b1; net_di = v;
    step();
    net_si = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; polarity = 1'b0; net_ro = 1'b0; net_si = 1'b1;
    net_di = 64'hDEAD_BEEF_0000_0001;
    idle();
    exp_dout = 64'h0;

    // Reset held 3 cycles with the router trying to send.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_net_ri", 64'(net_ri), 64'h0);
      check("rst_d_out", d_out, 64'h0);
    end
    reset = 1'b1; net_si = 1'b0;
    pe_read(2'b11);
    check("rst_out_stat", d_out, 64'h2);

    // Inject a VC0 packet; it may leave only in a polarity=0 cycle.
    net_ro = 1'b1;
    sent_q.delete();
    pe_write(2'b10, 64'h0011_0101_1111_1111);
    for (int i = 0; i < 4; i++) step();
    check("vc0_sent_cnt", 64'(sent_q.size()), 64'd1);
    if (sent_q.size() > 0) check("vc0_pkt", sent_q[0], 64'h0011_0101_1111_1111);
    pe_read(2'b11);
    check("vc0_out_stat", d_out, 64'h2);

    // Out FIFO full: third write dropped, then drain in order.
    net_ro = 1'b0;
    sent_q.delete();
    pe_write(2'b10, 64'h0000_0000_0000_00A1);
    pe_write(2'b10, 64'h8000_0000_0000_00A2);
    pe_write(2'b10, 64'h0000_0000_0000_00A3);
    pe_read(2'b11);
    check("full_out_stat", d_out, 64'h0000_0000_0000_0201);
    net_ro = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("drain_cnt", 64'(sent_q.size()), 64'd2);
    if (sent_q.size() > 1) begin
      check("drain_0", sent_q[0], 64'h0000_0000_0000_00A1);
      check("drain_1", sent_q[1], 64'h8000_0000_0000_00A2);
    end

    // Input channel: two packets fill the in FIFO, reads return them in order.
    router_send(64'h8010_0101_2222_2222);
    router_send(64'h0011_0101_3333_3333);
    #1 check("in_full_ri", 64'(net_ri), 64'h0);
    pe_read(2'b01);
    check("in_full_stat", d_out, 64'h0000_0000_0000_0201);
    pe_read(2'b00);
    check("in_rd0", d_out, 64'h8010_0101_2222_2222);
    pe_read(2'b00);
    check("in_rd1", d_out, 64'h0011_0101_3333_3333);
    pe_read(2'b00);
    check("in_rd_empty", d_out, 64'h0);

    // Full in FIFO: PE read and router send in the same cycle -> no accept,
    // accept on the following cycle.
    router_send(64'h0000_0000_0000_00B1);
    router_send(64'h0000_0000_0000_00B2);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b00;
    net_si = 1'b1; net_di = 64'h0000_0000_0000_00C1;
    step();
    idle();
    check("sim_rd", d_out, 64'h0000_0000_0000_00B1);
    #1 check("sim_ri_next", 64'(net_ri), 64'h1);
    step();
    net_si = 1'b0;
    pe_read(2'b00);
    check("sim_rd_b2", d_out, 64'h0000_0000_0000_00B2);
    pe_read(2'b00);
    check("sim_rd_c1", d_out, 64'h0000_0000_0000_00C1);

    // Mid-operation reset with one packet in each FIFO.
    net_ro = 1'b0;
    pe_write(2'b10, 64'h0000_0000_0000_00D1);
    router_send(64'h0000_0000_0000_00E1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    pe_read(2'b01);
    check("mid_in_stat", d_out, 64'h2);
    pe_read(2'b11);
    check("mid_out_stat", d_out, 64'h2);
    net_ro = 1'b1;
    sent_q.delete();
    for (int i = 0; i < 4; i++) step();
    check("mid_no_send", 64'(sent_q.size()), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 99) != 0);
      nicEn   = ($urandom_range(0, 2) != 0);
      nicWrEn = $urandom_range(0, 1);
      addr    = 2'($urandom_range(0, 3));
      d_in    = {$urandom, $urandom};
      net_ro  = ($urandom_range(0, 3) != 0);
      net_si  = $urandom_range(0, 1);
      net_di  = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
